cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
// 32-bit single-bus CPU datapath: register file, PC, IR, MAR, MDR, Y, 64-bit Z (hi/lo), HI, LO and a combinational ALU.
// All transfers go over one 32-bit bus (BusMuxOut) and are sequenced cycle by cycle by an external control unit/testbench.
// One T-state = one Clock cycle; the source drives the bus, and the destination latches it on the next rising edge.
// PARAMETERS
// none (word width fixed at 32, register count fixed at R0..R15)
// PORTS
// Clock      in   1   system clock, all registers update on rising edge
// Clear      in   1   asynchronous active-low reset
// PCout, MDRout, Zlowout, ZHighout, R2out, R4out  in 1 each  bus source selects
// PCin, IRin, MARin, MDRin, Yin, HIin, LOin        in 1 each  load enables from bus
// R1in..R15in in  1 each  register load enables from bus
// ZLowIn, ZHighIn in 1 each  load Z low/high from ALU result
// IncPC      in   1   ALU forced to (bus + 1)
// Read       in   1   MDR input mux: 1=Mdatain, 0=bus
// AND        in   5   ALU operation code (IR[31:27] encoding)
// Cin        in   1   carry-in to ADD
// Mdatain    in   32  memory read data
// BusMuxOut  out  32  current bus value
// BEHAVIOUR
// - Clear low: PC, IR, MAR, MDR, Y, Zhi, Zlo, HI, LO, R0..R15 = 0 immediately; BusMuxOut therefore 0.
// - Bus priority when several outs are high: MDRout > PCout > Zlowout > ZHighout > R2out > R4out; none high -> 0.
// - Register with Xin=1 loads BusMuxOut at the rising edge; enables are level signals, latched once per edge.
// - MDR: when MDRin=1, MDR <= Read ? Mdatain : BusMuxOut.
// - ALU: A = Y, B = BusMuxOut, 64-bit result {rh, rl}; rh = 0 unless stated otherwise.
//   Codes: 00011 ADD A+B+Cin; 00100 SUB A-B; 00101 SHR A>>B[4:0]; 00110 SHL A<<B[4:0];
//   00111 ROR; 01000 ROL (by B[4:0]); 01001 AND A&B; 01010 OR A|B;
//   10000 NEG -B; 10001 NOT ~B; 01110 MUL; 01111 DIV; other codes: rl = 0.
// - IncPC=1 overrides AND: rl = BusMuxOut + 1.
// - All arithmetic is mod 2^32; no flags, and carry-out is discarded.
// - ZLowIn: Zlo <= rl. ZHighIn: Zhi <= rh. Both may be asserted in the same cycle.
// - Simultaneous load and drive of the same register: the bus carries the old value, and the register latches it.
// - R0 exists but has no bus enable and stays 0.
// - Clear asserted mid-sequence aborts it; all state is 0 on the first edge after release.
// - Fetch: T0 PCout,MARin,IncPC,ZLowIn; T1 Zlowout,PCin,Read,MDRin; T2 MDRout,IRin.
// CONFIGURATION
// - CPU_DATAPATH_MULDIV_EN defined: MUL gives signed 64-bit {rh,rl} = A*B.
//   DIV gives rl = A/B and rh = A%B (signed); when B = 0, rl = rh = 0.
// - Macro undefined: the MUL/DIV codes behave as undefined codes (rl = rh = 0), and no multiplier/divider is synthesized.
// TESTING
// 1) Clear low, then high -> BusMuxOut=0 and all registers 0; assert Clear mid-T3 -> Y=0 immediately.
// 2) Mdatain=0x22, Read+MDRin; then MDRout+R2in -> R2=0x22; same flow loads R4=0x24, R5=0x26.
// 3) Fetch with PC=0 and Mdatain=0x4A920000 -> MAR=0, PC=1, IR=0x4A920000 after T2.
// 4) T3 R2out,Yin; T4 R4out,AND=01001,ZLowIn; T5 Zlowout,R5in -> R5=0x00000020.
// 5) Y=0xFFFFFFFF, bus=1, ADD, Cin=1 -> Zlo=0x00000001; SUB 5-7 -> Zlo=0xFFFFFFFE; ROL 0x80000001 by 1 -> Zlo=0x00000003.
// 6) MACRO on: MUL 0x00010000*0x00010000 -> Zhi=1, Zlo=0; DIV 7/2 -> Zlo=3, Zhi=1.
//    MACRO off: same stimulus -> Zhi=Zlo=0.

Source files
------------

// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus CPU datapath with register file, PC, IR, MAR, MDR, Y, Z, HI, LO and ALU.
// Define CPU_DATAPATH_MULDIV_EN to build the signed MUL/DIV operations.
module cpu_datapath (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Zlowout,
    input  logic        ZHighout,
    input  logic        R2out,
    input  logic        R4out,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        ZLowIn,
    input  logic        ZHighIn,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  AND,
    input  logic        Cin,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut
);
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q, hi_q, lo_q;
    logic [31:0] r_q [16];
    logic [15:1] rin;
    logic [31:0] mdr_d, rl, rh;
    logic [63:0] yy;
    logic [4:0]  sh;

    assign rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in};
    assign BusMuxOut = MDRout ? mdr_q : PCout ? pc_q : Zlowout ? zlo_q :
                       ZHighout ? zhi_q : R2out ? r_q[2] : R4out ? r_q[4] : '0;
    assign mdr_d = Read ? Mdatain : BusMuxOut;
    assign sh = BusMuxOut[4:0];
    assign yy = {y_q, y_q};

`ifdef CPU_DATAPATH_MULDIV_EN
    logic signed [63:0] prod;
    logic signed [31:0] quo, rem;
    assign prod = $signed(y_q) * $signed(BusMuxOut);
    assign quo = (BusMuxOut == '0) ? '0 : $signed(y_q) / $signed(BusMuxOut);
    assign rem = (BusMuxOut == '0) ? '0 : $signed(y_q) % $signed(BusMuxOut);
`endif

    // Rotates use a doubled operand; rotate-left is rotate-right by the negated amount
    always_comb begin
        rh = '0;
        rl = '0;
        if (IncPC) rl = BusMuxOut + 32'd1;
        else case (AND)
            5'b00011: rl = y_q + BusMuxOut + {31'd0, Cin};
            5'b00100: rl = y_q - BusMuxOut;
            5'b00101: rl = y_q >> sh;
            5'b00110: rl = y_q << sh;
            5'b00111: rl = 32'(yy >> sh);
            5'b01000: rl = 32'(yy >> (5'd0 - sh));
            5'b01001: rl = y_q & BusMuxOut;
            5'b01010: rl = y_q | BusMuxOut;
            5'b10000: rl = 32'd0 - BusMuxOut;
            5'b10001: rl = ~BusMuxOut;
`ifdef CPU_DATAPATH_MULDIV_EN
            5'b01110: {rh, rl} = prod;
            5'b01111: begin
                rl = quo;
                rh = rem;
            end
`endif
            default: rl = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
        end else begin
            if (PCin)    pc_q  <= BusMuxOut;
            if (IRin)    ir_q  <= BusMuxOut;
            if (MARin)   mar_q <= BusMuxOut;
            if (MDRin)   mdr_q <= mdr_d;
            if (Yin)     y_q   <= BusMuxOut;
            if (HIin)    hi_q  <= BusMuxOut;
            if (LOin)    lo_q  <= BusMuxOut;
            if (ZLowIn)  zlo_q <= rl;
            if (ZHighIn) zhi_q <= rh;
            for (int i = 1; i < 16; i++) if (rin[i]) r_q[i] <= BusMuxOut;
        end
    end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed-vector bench for cpu_datapath with hand-computed expectations.
module tb_cpu_datapath;
    logic        Clock = 0, Clear = 0;
    logic        PCout, MDRout, Zlowout, ZHighout, R2out, R4out;
    logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin;
    logic [15:1] rin;
    logic        ZLowIn, ZHighIn, IncPC, Read, Cin;
    logic [4:0]  AND;
    logic [31:0] Mdatain = '0;
    logic [31:0] BusMuxOut;
    int checks = 0, failures = 0;

    cpu_datapath dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .R2out(R2out), .R4out(R4out),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin),
        .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
        .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]),
        .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .IncPC(IncPC), .Read(Read),
        .AND(AND), .Cin(Cin), .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {PCout, MDRout, Zlowout, ZHighout, R2out, R4out} = '0;
        {PCin, IRin, MARin, MDRin, Yin, HIin, LOin} = '0;
        rin = '0;
        {ZLowIn, ZHighIn, IncPC, Read, Cin} = '0;
        AND = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    task automatic alu_chk(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                           input logic c, input logic [31:0] elo, ehi);
        mdr_load(a);
        MDRout = 1; Yin = 1;
        tick();
        mdr_load(b);
        MDRout = 1; AND = op; Cin = c; ZLowIn = 1; ZHighIn = 1;
        tick();
        Zlowout = 1;
        #1 chk({tag, "_lo"}, BusMuxOut, elo);
        idle();
        ZHighout = 1;
        #1 chk({tag, "_hi"}, BusMuxOut, ehi);
        idle();
    endtask

    initial begin
        idle();
        #12;
        chk("rst_bus", BusMuxOut, 32'h0);
        PCout = 1;
        #1 chk("rst_pc", BusMuxOut, 32'h0);
        idle();
        chk("rst_y", dut.y_q, 32'h0);
        chk("rst_r5", dut.r_q[5], 32'h0);
        Clear = 1;
        tick();

        mdr_load(32'h22);
        MDRout = 1; rin[2] = 1;
        tick();
        mdr_load(32'h24);
        MDRout = 1; rin[4] = 1;
        tick();
        mdr_load(32'h26);
        MDRout = 1; rin[5] = 1;
        tick();
        R2out = 1;
        #1 chk("r2", BusMuxOut, 32'h22);
        idle();
        R4out = 1;
        #1 chk("r4", BusMuxOut, 32'h24);
        idle();
        chk("r5", dut.r_q[5], 32'h26);

        PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1;
        tick();
        chk("t0_mar", dut.mar_q, 32'h0);
        Mdatain = 32'h4A920000; Zlowout = 1; PCin = 1; Read = 1; MDRin = 1;
        tick();
        MDRout = 1; IRin = 1;
        tick();
        chk("t2_ir", dut.ir_q, 32'h4A920000);
        PCout = 1;
        #1 chk("t2_pc", BusMuxOut, 32'h1);
        idle();

        R2out = 1; Yin = 1;
        tick();
        R4out = 1; AND = 5'b01001; ZLowIn = 1;
        tick();
        Zlowout = 1; rin[5] = 1;
        tick();
        chk("t5_r5", dut.r_q[5], 32'h20);

        MDRout = 1; PCout = 1;
        #1 chk("pri_mdr", BusMuxOut, 32'h4A920000);
        idle();
        PCout = 1; Zlowout = 1;
        #1 chk("pri_pc", BusMuxOut, 32'h1);
        idle();
        Zlowout = 1; ZHighout = 1;
        #1 chk("pri_zlo", BusMuxOut, 32'h20);
        idle();
        ZHighout = 1; R2out = 1;
        #1 chk("pri_zhi", BusMuxOut, 32'h0);
        idle();
        R2out = 1; R4out = 1;
        #1 chk("pri_r2", BusMuxOut, 32'h22);
        idle();

        R2out = 1; rin[2] = 1;
        tick();
        R2out = 1;
        #1 chk("self_r2", BusMuxOut, 32'h22);
        idle();
        PCout = 1; PCin = 1;
        tick();
        PCout = 1;
        #1 chk("self_pc", BusMuxOut, 32'h1);
        idle();

        alu_chk("add", 5'b00011, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 32'h0);
        alu_chk("sub", 5'b00100, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 32'h0);
        alu_chk("rol", 5'b01000, 32'h80000001, 32'h1, 1'b0, 32'h3, 32'h0);
        alu_chk("ror", 5'b00111, 32'h3, 32'h1, 1'b0, 32'h80000001, 32'h0);
        alu_chk("rol0", 5'b01000, 32'h12345678, 32'h20, 1'b0, 32'h12345678, 32'h0);
        alu_chk("shr", 5'b00101, 32'h80000000, 32'h4, 1'b0, 32'h08000000, 32'h0);
        alu_chk("shl", 5'b00110, 32'h1, 32'h1F, 1'b0, 32'h80000000, 32'h0);
        alu_chk("or", 5'b01010, 32'hF0, 32'h0F, 1'b0, 32'hFF, 32'h0);
        alu_chk("neg", 5'b10000, 32'h0, 32'h5, 1'b0, 32'hFFFFFFFB, 32'h0);
        alu_chk("not", 5'b10001, 32'h0, 32'h0F0F0F0F, 1'b0, 32'hF0F0F0F0, 32'h0);
        alu_chk("undef", 5'b00000, 32'h5, 32'h7, 1'b1, 32'h0, 32'h0);
`ifdef CPU_DATAPATH_MULDIV_EN
        alu_chk("mul", 5'b01110, 32'h00010000, 32'h00010000, 1'b0, 32'h0, 32'h1);
        alu_chk("muls", 5'b01110, 32'hFFFFFFFF, 32'h2, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF);
        alu_chk("div", 5'b01111, 32'h7, 32'h2, 1'b0, 32'h3, 32'h1);
        alu_chk("div0", 5'b01111, 32'h7, 32'h0, 1'b0, 32'h0, 32'h0);
`else
        alu_chk("mul", 5'b01110, 32'h00010000, 32'h00010000, 1'b0, 32'h0, 32'h0);
        alu_chk("div", 5'b01111, 32'h7, 32'h2, 1'b0, 32'h0, 32'h0);
`endif

        R2out = 1; Yin = 1;
        #1 Clear = 0;
        #1 chk("clr_y", dut.y_q, 32'h0);
        chk("clr_bus", BusMuxOut, 32'h0);
        idle();
        #1 Clear = 1;
        tick();
        R2out = 1;
        #1 chk("clr_r2", BusMuxOut, 32'h0);
        idle();
        PCout = 1;
        #1 chk("clr_pc", BusMuxOut, 32'h0);
        idle();
        chk("clr_ir", dut.ir_q, 32'h0);
        chk("r0", dut.r_q[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
